// File: rtl/uart_transmitter.sv
// 8-E-1 UART transmitter with a small input FIFO. The parity bit is present only when
// UART_TX_PARITY_EN is defined; otherwise frames are 8-N-1.
module uart_transmitter #(
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned CLOCK_FREQ = 50000000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [7:0]                  data_in,
    input  logic                        data_valid,
    output logic                        ready,
    output logic                        Tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic [15:0]                 BAUD_counter
);

    localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned AW           = $clog2(FIFO_DEPTH);
    localparam logic [15:0] BIT_LAST     = 16'(CLKS_PER_BIT - 1);
    localparam logic [AW:0] COUNT_FULL   = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] COUNT_ONE    = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
`ifdef UART_TX_PARITY_EN
        StParity = 3'd3,
`endif
        StStop   = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [AW:0]   w_count_next;
    logic          r_ready;

    logic [15:0]   r_baud;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_next;
    logic          r_tx;
    logic          w_tx_next;
`ifdef UART_TX_PARITY_EN
    logic          r_parity;
    logic          w_parity_next;
`endif

    logic          w_push;
    logic          w_pop;
    logic          w_bit_done;
    logic          w_data_last;

    assign w_push      = data_valid && r_ready && !rst;
    assign w_pop       = (r_state == StIdle) && enable && (r_count != '0);
    assign w_bit_done  = (r_baud == BIT_LAST);
    assign w_data_last = w_bit_done && (r_bit_idx == 3'd7);

    // FIFO storage and bookkeeping
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + COUNT_ONE;
            2'b01:   w_count_next = r_count - COUNT_ONE;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_count <= w_count_next;
            r_ready <= (w_count_next != COUNT_FULL);
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:   if (w_pop) w_state_next = StStart;
            StStart:  if (w_bit_done) w_state_next = StData;
`ifdef UART_TX_PARITY_EN
            StData:   if (w_data_last) w_state_next = StParity;
            StParity: if (w_bit_done) w_state_next = StStop;
`else
            StData:   if (w_data_last) w_state_next = StStop;
`endif
            StStop:   if (w_bit_done) w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    // Output logic: Tx is computed for the next state so it can be driven from a flop
    always_comb begin
        w_shift_next = r_shift;
        if (w_pop) begin
            w_shift_next = r_mem[r_rd_ptr];
        end else if ((r_state == StData) && w_bit_done) begin
            w_shift_next = {1'b0, r_shift[7:1]};
        end
`ifdef UART_TX_PARITY_EN
        w_parity_next = r_parity;
        if (w_pop) begin
            w_parity_next = 1'b0;
        end else if ((r_state == StData) && w_bit_done) begin
            w_parity_next = r_parity ^ r_shift[0];
        end
`endif
        w_tx_next = 1'b1;
        case (w_state_next)
            StStart:  w_tx_next = 1'b0;
            StData:   w_tx_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
            StParity: w_tx_next = w_parity_next;
`endif
            default:  w_tx_next = 1'b1;
        endcase
        busy = (r_state != StIdle);
    end

    // Bit timing and shift datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            if ((r_state == StIdle) || w_bit_done) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + 16'd1;
            end
            if (r_state == StStart) begin
                r_bit_idx <= '0;
            end else if ((r_state == StData) && w_bit_done) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            r_shift <= w_shift_next;
            r_tx    <= w_tx_next;
`ifdef UART_TX_PARITY_EN
            r_parity <= w_parity_next;
`endif
        end
    end

    assign Tx           = r_tx;
    assign ready        = r_ready;
    assign fifo_count   = r_count;
    assign BAUD_counter = r_baud;

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: a frame-level reference model checked every
// cycle, a table of known frames sampled mid-bit, and directed multi-cycle sequences.
module tb_uart_transmitter;

    localparam int CLK_F = 80;
    localparam int BAUD  = 10;
    localparam int C     = CLK_F / BAUD;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB  = 11;
    localparam bit PAR = 1'b1;
`else
    localparam int NB  = 10;
    localparam bit PAR = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     enable;
    logic [7:0]               data_in;
    logic                     data_valid;
    logic                     ready;
    logic                     tx;
    logic                     busy;
    logic [$clog2(DEPTH):0]   fifo_count;
    logic [15:0]              baud_counter;

    uart_transmitter #(
        .BAUD_RATE  (BAUD),
        .CLOCK_FREQ (CLK_F),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .ready        (ready),
        .Tx           (tx),
        .busy         (busy),
        .fifo_count   (fifo_count),
        .BAUD_counter (baud_counter)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Reference model: queue of pending bytes plus the frame on the line, tracked by elapsed time
    logic [7:0]  m_q[$];
    bit          m_active = 1'b0;
    int          m_t = 0;
    logic [10:0] m_bits;

    function automatic void model_edge();
        int  old_size;
        bit  do_push;
        logic [7:0] b;
        if (rst) begin
            m_q.delete();
            m_active = 1'b0;
            m_t = 0;
            return;
        end
        old_size = m_q.size();
        do_push  = data_valid && (old_size < DEPTH);
        if (m_active) begin
            m_t++;
            if (m_t == NB * C) m_active = 1'b0;
        end else if (enable && old_size > 0) begin
            b = m_q.pop_front();
            m_bits = '1;
            m_bits[0] = 1'b0;
            for (int i = 0; i < 8; i++) m_bits[1 + i] = b[i];
            if (PAR) m_bits[9] = ^b;
            m_active = 1'b1;
            m_t = 0;
        end
        if (do_push) m_q.push_back(data_in);
    endfunction

    task automatic compare_model();
        logic        e_tx;
        logic        e_busy;
        logic        e_ready;
        int          e_cnt;
        int          e_baud;
        e_tx    = m_active ? m_bits[m_t / C] : 1'b1;
        e_busy  = m_active;
        e_cnt   = m_q.size();
        e_ready = (e_cnt != DEPTH);
        e_baud  = m_active ? (m_t % C) : 0;
        n_vec++;
        if (tx !== e_tx || busy !== e_busy || ready !== e_ready ||
            int'(fifo_count) != e_cnt || int'(baud_counter) != e_baud) begin
            n_bad++;
            $display("FAIL model_cycle @%0t: Tx/busy/ready/count/baud got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d",
                     $time, tx, busy, ready, fifo_count, baud_counter,
                     e_tx, e_busy, e_ready, e_cnt, e_baud);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        if (chk_en) compare_model();
    endtask

    task automatic check(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic wait_busy(input string name);
        for (int k = 0; k < 8 && busy !== 1'b1; k++) tick();
        check(name, int'(busy === 1'b1), 1);
    endtask

    function automatic logic line_bit(input logic [10:0] line, input int j);
        if (PAR || j < 9) return line[j];
        return line[10];
    endfunction

    typedef struct {
        logic [7:0]  data;
        logic [10:0] line;   // expected 8-E-1 line bits, index 0 = start bit
    } vec_t;

    vec_t vecs[5];

    initial begin
        int frames;
        int low_run;
        int bc;
        bit prev;

        vecs[0] = '{data: 8'hB1, line: 11'b10101100010};
        vecs[1] = '{data: 8'h07, line: 11'b11000001110};
        vecs[2] = '{data: 8'h00, line: 11'b10000000000};
        vecs[3] = '{data: 8'hFF, line: 11'b10111111110};
        vecs[4] = '{data: 8'h80, line: 11'b11100000000};

        // Reset held for two cycles with a write strobe present
        rst = 1'b1; enable = 1'b0; data_valid = 1'b1; data_in = 8'hA5;
        tick();
        chk_en = 1'b1;
        tick();
        check("reset_tx", int'(tx), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_ready", int'(ready), 1);
        check("reset_count", int'(fifo_count), 0);
        rst = 1'b0; data_valid = 1'b0;
        tick();

        // Known frames sampled at mid-bit
        enable = 1'b1;
        foreach (vecs[v]) begin
            data_in = vecs[v].data; data_valid = 1'b1;
            tick();
            data_valid = 1'b0;
            wait_busy("table_start");
            bc = 0;
            for (int j = 0; j < NB; j++) begin
                for (int c = 0; c < C; c++) begin
                    if (c == C / 2) check($sformatf("table_%02h_bit%0d", vecs[v].data, j),
                                          int'(tx), int'(line_bit(vecs[v].line, j)));
                    if (busy) bc++;
                    tick();
                end
            end
            check("table_busy_len", bc, NB * C);
            check("table_tx_after", int'(tx), 1);
            tick();
        end

        // Burst of six writes while disabled: four fit, two are dropped
        enable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            data_in = 8'($urandom); data_valid = 1'b1;
            tick();
        end
        data_valid = 1'b0;
        check("burst_count", int'(fifo_count), 4);
        check("burst_ready", int'(ready), 0);
        enable = 1'b1;
        frames = 0; low_run = 0; prev = 1'b0;
        for (int k = 0; k < 4 * (NB * C + 1) + 10; k++) begin
            tick();
            if (busy) begin
                if (!prev) begin
                    frames++;
                    if (frames > 1) check("burst_gap", low_run, 1);
                end
                low_run = 0;
            end else begin
                low_run++;
            end
            prev = busy;
        end
        check("burst_frames", frames, 4);
        check("burst_drained", int'(fifo_count), 0);

        // Push in the same cycle as the idle pop
        enable = 1'b0;
        data_in = 8'h3C; data_valid = 1'b1;
        tick();
        enable = 1'b1; data_in = 8'hC3;
        tick();
        data_valid = 1'b0;
        check("pushpop_count", int'(fifo_count), 1);
        check("pushpop_busy", int'(busy), 1);
        frames = 0; prev = 1'b1;
        for (int k = 0; k < 2 * (NB * C + 1) + 10; k++) begin
            tick();
            if (busy && !prev) frames++;
            prev = busy;
        end
        check("pushpop_second_frame", frames, 1);
        check("pushpop_idle", int'(busy), 0);

        // Reset in data bit 3 of 0x55 with two bytes still queued
        enable = 1'b0;
        data_valid = 1'b1;
        data_in = 8'h55; tick();
        data_in = 8'h33; tick();
        data_in = 8'h0F; tick();
        data_valid = 1'b0;
        enable = 1'b1;
        wait_busy("rst_mid_start");
        for (int k = 0; k < 4 * C + C / 2; k++) tick();
        check("rst_mid_bit3", int'(tx), 0);
        check("rst_mid_queued", int'(fifo_count), 2);
        rst = 1'b1;
        tick();
        check("rst_mid_tx", int'(tx), 1);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_count", int'(fifo_count), 0);
        rst = 1'b0;
        bc = 0;
        for (int k = 0; k < 2 * NB * C; k++) begin
            tick();
            if (busy) bc++;
        end
        check("rst_mid_no_frames", bc, 0);

        // Random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            rst        = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 49) == 0) enable = ~enable;
            data_valid = ($urandom_range(0, 3) == 0);
            data_in    = 8'($urandom);
            tick();
        end
        rst = 1'b0; data_valid = 1'b0; enable = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
Serialises bytes into 8-E-1 UART frames on a single Tx line: start bit, 8 data bits LSB first, even parity bit, stop bit. It is the upstream peer of the UART receiver, and its Tx output drives the receiver's Rx in loopback configurations. A small input FIFO lets the CPU side push bursts of bytes without waiting on the line rate.

Parameters:
BAUD_RATE, 9600, line bit rate in bits/s
CLOCK_FREQ, 50000000, clk frequency in Hz
FIFO_DEPTH, 4, input FIFO entries; must be a power of 2, range 2..16

Ports:
clk  input  1  system clock; all logic is on the rising edge
rst  input  1  synchronous, active-high reset
enable  input  1  when high, new frames may start
data_in  input  8  byte to transmit
data_valid  input  1  write strobe for data_in
ready  output  1  FIFO not full; a write is accepted when data_valid && ready
Tx  output  1  serial line, idle high
busy  output  1  high while a frame is in flight (state != IDLE)
fifo_count  output  $clog2(FIFO_DEPTH)+1  number of bytes queued
BAUD_counter  output  16  cycle counter within the current bit, for debug

Behaviour:
- One clock; reset is synchronous and active-high. Port names are clk and rst.
- CLKS_PER_BIT = CLOCK_FREQ/BAUD_RATE, using integer division (5208 at the defaults). BAUD_counter is 16 bits wide.
- Reset values: Tx=1, busy=0, ready=1, fifo_count=0, BAUD_counter=0, state=IDLE, FIFO emptied.
- ready is a registered function of fifo_count: ready = (fifo_count != FIFO_DEPTH).
- A write with data_valid=1 while ready=0 is dropped silently, with no state change.
- Simultaneous push and pop: fifo_count is unchanged and both operations take effect.
- The FIFO pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: Tx=1. If enable=1 and fifo_count>0 at a rising edge, pop the head byte into the shift register, clear the parity accumulator, clear BAUD_counter, and go to START.
  - START: Tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: Tx=shift[0]. Each bit holds for CLKS_PER_BIT cycles. At the end of each bit, shift right and XOR the bit into the parity accumulator. After bit index 7 completes, go to PARITY.
  - PARITY: Tx = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: Tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- BAUD_counter counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary. It is held at 0 in IDLE.
- Latency: a byte written at edge E0 into an empty FIFO, with the FSM idle and enable=1, is popped at E1. Tx falls at E1.
- Frame length is 11*CLKS_PER_BIT cycles. Back-to-back frames have exactly 1 IDLE cycle (Tx=1) between the end of STOP and the next START.
- enable deasserted mid-frame: the current frame completes normally and no new frame starts. Queued bytes are retained.
- Reset mid-frame: on the next edge Tx=1 and state=IDLE, and all queued bytes are discarded. No partial frame resumes.
- Tx is driven from a flop, so it never glitches.

Optional Feature:
UART_TX_PARITY_EN. The default build defines it, to match the receiver's 9-bit frame.
- Defined: the PARITY state is present and frames are 11 bits (8-E-1).
- Not defined: the PARITY state is removed, DATA goes directly to STOP, and frames are 10 bits (8-N-1), i.e. 10*CLKS_PER_BIT cycles. The parity accumulator logic is not synthesised.

Test Plan:
- Reset: assert rst for 2 cycles with data_valid=1 -> Tx=1, busy=0, ready=1, fifo_count=0; no write is accepted during reset.
- Single byte 0xB1 with defaults: sample Tx at mid-bit, 2604 cycles into each 5208-cycle bit -> bits 0,1,0,0,0,1,1,0,1,0,1 (start, LSB-first data, parity 0, stop); busy is high for exactly 57288 cycles; then Tx=1.
- Parity check, byte 0x07 -> parity bit = 1. Byte 0x00 -> parity bit = 0 and all data bits 0.
- Burst of 6 back-to-back writes while enable=0 -> writes 1-4 accepted, fifo_count=4, ready=0, writes 5-6 dropped. Then raise enable -> exactly 4 frames are sent, each separated by 1 idle cycle.
- Push while popping: write at the edge where IDLE pops with fifo_count=1 -> fifo_count stays 1 and the second frame follows.
- Reset mid-DATA (bit 3 of 0x55) with 2 bytes queued -> next edge: Tx=1, busy=0, fifo_count=0; no further frames are sent.
